ucore_sequencer: RTL and testbench

- Parametrised successor to the generated per-program FSM cores: a generic microprogram sequencer executing microcode from an external synchronous ROM.
- Adds features the generated cores lack: selectable entry point, conditional branch, wait-on-condition, call/return stack, abort, and error reporting.
- Sits between a microcode ROM and the datapath; drives a registered control word each executed cycle.

---
 rtl/ucore_pkg.sv | 47 ++++
 rtl/ucore_call_stack.sv | 54 +++++
 rtl/ucore_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ucore_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucore_pkg.sv
// ucore_pkg: shared definitions for the microcode sequencer.
//   - opcode values of the 3-bit op field
//   - sequencer state encoding
//   - helpers that derive instruction field widths/offsets from the
//     address, control-word and condition-count parameters
// Instruction layout, MSB to LSB: op | sel | target | ctrl
package ucore_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BRT  = 3'd2;
  localparam logic [2:0] OP_BRF  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_WAIT = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // A single condition input still needs a 1-bit select field.
  function automatic int cond_sel_w(input int num_cond);
    return (num_cond > 1) ? $clog2(num_cond) : 1;
  endfunction

  function automatic int target_lsb(input int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int sel_lsb(input int addr_w, input int ctrl_w);
    return ctrl_w + addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w, input int ctrl_w, input int num_cond);
    return ctrl_w + addr_w + cond_sel_w(num_cond);
  endfunction

  function automatic int instr_w(input int addr_w, input int ctrl_w, input int num_cond);
    return OP_W + cond_sel_w(num_cond) + addr_w + ctrl_w;
  endfunction

endpackage

// File: rtl/ucore_call_stack.sv
// ucore_call_stack: DEPTH x WIDTH LIFO holding return addresses.
//   clk, rst      clock, asynchronous active-high reset (empties the stack)
//   clear         synchronous empty, wins over push/pop
//   push, pop     single-cycle operations; ignored when full / empty
//   push_data     value pushed
//   top_data      most recently pushed value (meaningless when empty)
//   full, empty   occupancy flags
module ucore_call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] top_idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = IDX_W'(count) - IDX_W'(1);
  assign top_data = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entries need no reset: only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[IDX_W'(count)] <= push_data;
    end
  end

endmodule

// File: rtl/ucore_sequencer.sv
// ucore_sequencer: generic microprogram sequencer fed by a synchronous ROM.
//   clk, areset   clock, asynchronous active-high reset
//   start         begin execution at entry_addr (accepted in IDLE or ERR)
//   entry_addr    program entry point
//   abort         stop a running program, back to IDLE without done
//   cond          condition flags tested by BRT/BRF/WAIT
//   rom_addr      combinational ROM address = upc of the next cycle
//   rom_data      instruction fetched from the previous rom_addr
//   ctrl_out      registered control word to the datapath
//   upc           current micro-PC
//   busy          registered, high while running
//   done          one-cycle pulse when HALT executes
//   error         sticky call-stack overflow/underflow flag
module ucore_sequencer
  import ucore_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int CTRL_W      = 16,
  parameter int NUM_COND    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                       clk,
  input  logic                                       areset,
  input  logic                                       start,
  input  logic [ADDR_W-1:0]                          entry_addr,
  input  logic                                       abort,
  input  logic [NUM_COND-1:0]                        cond,
  output logic [ADDR_W-1:0]                          rom_addr,
  input  logic [instr_w(ADDR_W, CTRL_W, NUM_COND)-1:0] rom_data,
  output logic [CTRL_W-1:0]                          ctrl_out,
  output logic [ADDR_W-1:0]                          upc,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       error
);

  localparam int SEL_W   = cond_sel_w(NUM_COND);
  localparam int TGT_LSB = target_lsb(CTRL_W);
  localparam int SEL_LSB = sel_lsb(ADDR_W, CTRL_W);
  localparam int OP_LSB  = op_lsb(ADDR_W, CTRL_W, NUM_COND);

  logic [OP_W-1:0]   op;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] target;
  logic [CTRL_W-1:0] ctrl;
  logic              cond_bit;
  logic [ADDR_W-1:0] upc_inc;

  logic [ADDR_W-1:0] next_pc;
  logic              want_push;
  logic              want_pop;
  logic              fault;
  logic              halt;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] upc_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              done_d;
  logic              error_d;

  logic              stack_clear;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full;
  logic              stack_empty;

  assign op      = rom_data[OP_LSB +: OP_W];
  assign sel     = rom_data[SEL_LSB +: SEL_W];
  assign target  = rom_data[TGT_LSB +: ADDR_W];
  assign ctrl    = rom_data[0 +: CTRL_W];
  assign upc_inc = upc + ADDR_W'(1);

  // Selects beyond the implemented flags fall back to condition 0.
  assign cond_bit = (int'(sel) >= NUM_COND) ? cond[0] : cond[sel];

  ucore_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst       (areset),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (upc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next-address decode of the instruction at upc. A stack fault or HALT
  // leaves the PC where it is, so the ROM keeps presenting that address.
  always_comb begin
    next_pc   = upc_inc;
    want_push = 1'b0;
    want_pop  = 1'b0;
    fault     = 1'b0;
    halt      = 1'b0;
    case (op)
      OP_NEXT: next_pc = upc_inc;
      OP_JUMP: next_pc = target;
      OP_BRT:  if (cond_bit) next_pc = target;
      OP_BRF:  if (!cond_bit) next_pc = target;
      OP_CALL: begin
        if (stack_full) begin
          fault   = 1'b1;
          next_pc = upc;
        end else begin
          want_push = 1'b1;
          next_pc   = target;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          fault   = 1'b1;
          next_pc = upc;
        end else begin
          want_pop = 1'b1;
          next_pc  = stack_top;
        end
      end
      OP_WAIT: if (!cond_bit) next_pc = upc;
      OP_HALT: begin
        halt    = 1'b1;
        next_pc = upc;
      end
      default: next_pc = upc_inc;
    endcase
  end

  // Sequencer next state. Abort outranks everything the instruction would
  // do, including stack pushes/pops and fault detection.
  always_comb begin
    state_d     = state;
    upc_d       = upc;
    ctrl_d      = ctrl_out;
    done_d      = 1'b0;
    error_d     = error;
    stack_clear = 1'b0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    rom_addr    = entry_addr;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          error_d     = 1'b0;
          upc_d       = entry_addr;
          stack_clear = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        rom_addr = next_pc;
        if (abort) begin
          state_d = ST_IDLE;
          ctrl_d  = '0;
        end else if (fault) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          ctrl_d  = '0;
        end else if (halt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ctrl_d  = '0;
        end else begin
          ctrl_d     = ctrl;
          upc_d      = next_pc;
          stack_push = want_push;
          stack_pop  = want_pop;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      upc      <= '0;
      ctrl_out <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      upc      <= upc_d;
      ctrl_out <= ctrl_d;
      done     <= done_d;
      error    <= error_d;
      busy     <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_ucore_sequencer.sv
// tb_ucore_sequencer: self-checking bench for ucore_sequencer with default
// parameters (12-bit addresses, 16-bit control, 8 conditions, 4-deep stack).
// A behavioural ROM feeds the DUT; an instruction-level model tracks the
// expected outputs every cycle.
module tb_ucore_sequencer;

  localparam int AW = 12;
  localparam int CW = 16;
  localparam int IW = 34;
  localparam int DEPTH = 4;

  logic          clk;
  logic          areset;
  logic          start;
  logic [AW-1:0] entry_addr;
  logic          abort;
  logic [7:0]    cond;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic [CW-1:0] ctrl_out;
  logic [AW-1:0] upc;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] rom [0:4095];
  logic [AW-1:0] last_ra;

  // Model state: 0 idle, 1 running, 2 stack error
  int            m_state;
  logic [AW-1:0] m_upc;
  logic [CW-1:0] m_ctrl;
  logic          m_done;
  logic          m_error;
  logic [AW-1:0] m_stack[$];

  typedef struct {
    logic          start;
    logic [AW-1:0] entry;
    logic [AW-1:0] ra;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] upc;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[5];

  ucore_sequencer dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .entry_addr (entry_addr),
    .abort      (abort),
    .cond       (cond),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ctrl_out   (ctrl_out),
    .upc        (upc),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for the address presented in the previous cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [2:0] sel,
                                       input logic [AW-1:0] tgt, input logic [CW-1:0] ctl);
    return {op, sel, tgt, ctl};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = mk(3'd7, 3'd0, 12'h000, 16'h0000);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_upc   = '0;
    m_ctrl  = '0;
    m_done  = 1'b0;
    m_error = 1'b0;
    m_stack.delete();
  endtask

  // Executes one cycle of the program semantics on the current inputs and
  // returns the address the sequencer should present to the ROM.
  task automatic model_step(output logic [AW-1:0] ra);
    logic [2:0]    op;
    logic [2:0]    sel;
    logic [AW-1:0] tgt;
    logic [CW-1:0] ctl;
    logic [AW-1:0] nxt;
    logic [AW-1:0] inc;
    logic          c;
    logic          flt;
    logic          hlt;
    m_done = 1'b0;
    if (m_state != 1) begin
      ra = entry_addr;
      if (start) begin
        m_error = 1'b0;
        m_upc   = entry_addr;
        m_stack.delete();
        m_state = 1;
      end
    end else begin
      {op, sel, tgt, ctl} = rom[m_upc];
      c   = cond[sel];
      inc = 12'((int'(m_upc) + 1) % 4096);
      nxt = inc;
      flt = 1'b0;
      hlt = 1'b0;
      case (op)
        3'd1: nxt = tgt;
        3'd2: if (c) nxt = tgt;
        3'd3: if (!c) nxt = tgt;
        3'd4: if (m_stack.size() == DEPTH) flt = 1'b1; else nxt = tgt;
        3'd5: if (m_stack.size() == 0) flt = 1'b1; else nxt = m_stack[$];
        3'd6: if (!c) nxt = m_upc;
        3'd7: hlt = 1'b1;
        default: nxt = inc;
      endcase
      if (flt || hlt) nxt = m_upc;
      ra = nxt;
      if (abort) begin
        m_state = 0;
        m_ctrl  = '0;
      end else if (flt) begin
        m_state = 2;
        m_error = 1'b1;
        m_ctrl  = '0;
      end else if (hlt) begin
        m_state = 0;
        m_done  = 1'b1;
        m_ctrl  = '0;
      end else begin
        if (op == 3'd4) m_stack.push_back(inc);
        if (op == 3'd5) void'(m_stack.pop_back());
        m_ctrl = ctl;
        m_upc  = nxt;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; drives inputs for the coming
  // edge, checks rom_addr before it and the registered outputs after it.
  task automatic applyStimulus(input logic s, input logic [AW-1:0] e, input logic a, input logic [7:0] c);
    logic [AW-1:0] exp_ra;
    start      = s;
    entry_addr = e;
    abort      = a;
    cond       = c;
    #1;
    last_ra = rom_addr;
    model_step(exp_ra);
    checkOutput("rom_addr", 32'(rom_addr), 32'(exp_ra));
    @(posedge clk);
    #1;
    checkOutput("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
    checkOutput("upc", 32'(upc), 32'(m_upc));
    checkOutput("busy", 32'(busy), 32'(m_state == 1));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("error", 32'(error), 32'(m_error));
  endtask

  initial begin
    areset     = 1'b1;
    start      = 1'b0;
    entry_addr = '0;
    abort      = 1'b0;
    cond       = '0;
    clear_rom();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", 32'(ctrl_out), 32'h0);
    checkOutput("reset_upc", 32'(upc), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_error", 32'(error), 32'h0);
    areset = 1'b0;

    // Straight-line program with HALT, checked against a fixed table
    rom[12'h010] = mk(3'd0, 3'd0, 12'h000, 16'h0001);
    rom[12'h011] = mk(3'd0, 3'd0, 12'h000, 16'h0002);
    rom[12'h012] = mk(3'd7, 3'd0, 12'h000, 16'hBEEF);
    vecs[0] = '{1'b1, 12'h010, 12'h010, 16'h0000, 12'h010, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 12'h010, 12'h011, 16'h0001, 12'h011, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 12'h010, 12'h012, 16'h0002, 12'h012, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 12'h010, 12'h012, 16'h0000, 12'h012, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 12'h010, 12'h010, 16'h0000, 12'h012, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].start, vecs[i].entry, 1'b0, 8'h00);
      checkOutput($sformatf("tbl%0d_ra", i), 32'(last_ra), 32'(vecs[i].ra));
      checkOutput($sformatf("tbl%0d_ctrl", i), 32'(ctrl_out), 32'(vecs[i].ctrl));
      checkOutput($sformatf("tbl%0d_upc", i), 32'(upc), 32'(vecs[i].upc));
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].done));
    end

    // Conditional branch taken and not taken
    rom[12'h020] = mk(3'd2, 3'd3, 12'h040, 16'h000A);
    applyStimulus(1'b1, 12'h020, 1'b0, 8'h08);
    applyStimulus(1'b0, 12'h020, 1'b0, 8'h08);
    checkOutput("brt_taken_upc", 32'(upc), 32'h040);
    applyStimulus(1'b0, 12'h020, 1'b0, 8'h00);
    applyStimulus(1'b1, 12'h020, 1'b0, 8'h00);
    applyStimulus(1'b0, 12'h020, 1'b0, 8'h00);
    checkOutput("brt_not_taken_upc", 32'(upc), 32'h021);
    applyStimulus(1'b0, 12'h020, 1'b0, 8'h00);

    // WAIT holds for five cycles, then advances
    rom[12'h030] = mk(3'd6, 3'd1, 12'h000, 16'h0033);
    applyStimulus(1'b1, 12'h030, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 12'h030, 1'b0, 8'h00);
      checkOutput("wait_hold_upc", 32'(upc), 32'h030);
      checkOutput("wait_hold_ctrl", 32'(ctrl_out), 32'h0033);
    end
    applyStimulus(1'b0, 12'h030, 1'b0, 8'h02);
    checkOutput("wait_release_upc", 32'(upc), 32'h031);
    applyStimulus(1'b0, 12'h030, 1'b0, 8'h00);

    // Nested calls to full depth and matching returns
    rom[12'h100] = mk(3'd4, 3'd0, 12'h200, 16'h0100);
    rom[12'h200] = mk(3'd4, 3'd0, 12'h300, 16'h0200);
    rom[12'h300] = mk(3'd4, 3'd0, 12'h400, 16'h0300);
    rom[12'h400] = mk(3'd4, 3'd0, 12'h500, 16'h0400);
    rom[12'h500] = mk(3'd5, 3'd0, 12'h000, 16'h0500);
    rom[12'h401] = mk(3'd5, 3'd0, 12'h000, 16'h0401);
    rom[12'h301] = mk(3'd5, 3'd0, 12'h000, 16'h0301);
    rom[12'h201] = mk(3'd5, 3'd0, 12'h000, 16'h0201);
    begin
      logic [AW-1:0] seq [8];
      seq = '{12'h200, 12'h300, 12'h400, 12'h500, 12'h401, 12'h301, 12'h201, 12'h101};
      applyStimulus(1'b1, 12'h100, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b0, 12'h100, 1'b0, 8'h00);
        checkOutput($sformatf("call_ret_upc%0d", i), 32'(upc), 32'(seq[i]));
      end
      applyStimulus(1'b0, 12'h100, 1'b0, 8'h00);
      checkOutput("call_ret_done", 32'(done), 32'h1);
    end

    // One CALL too many, then recovery through start
    rom[12'h500] = mk(3'd4, 3'd0, 12'h600, 16'h0555);
    applyStimulus(1'b1, 12'h100, 1'b0, 8'h00);
    repeat (4) applyStimulus(1'b0, 12'h100, 1'b0, 8'h00);
    applyStimulus(1'b0, 12'h100, 1'b0, 8'h00);
    checkOutput("overflow_error", 32'(error), 32'h1);
    checkOutput("overflow_busy", 32'(busy), 32'h0);
    checkOutput("overflow_ctrl", 32'(ctrl_out), 32'h0);
    applyStimulus(1'b0, 12'h010, 1'b0, 8'h00);
    applyStimulus(1'b1, 12'h010, 1'b0, 8'h00);
    checkOutput("restart_error", 32'(error), 32'h0);
    checkOutput("restart_busy", 32'(busy), 32'h1);
    repeat (3) applyStimulus(1'b0, 12'h010, 1'b0, 8'h00);

    // Address wrap at the top of the microcode space
    rom[12'h050] = mk(3'd1, 3'd0, 12'hFFF, 16'h0050);
    rom[12'hFFF] = mk(3'd0, 3'd0, 12'h000, 16'h0FFF);
    applyStimulus(1'b1, 12'h050, 1'b0, 8'h00);
    applyStimulus(1'b0, 12'h050, 1'b0, 8'h00);
    checkOutput("jump_upc", 32'(upc), 32'hFFF);
    applyStimulus(1'b0, 12'h050, 1'b0, 8'h00);
    checkOutput("wrap_upc", 32'(upc), 32'h000);
    applyStimulus(1'b0, 12'h050, 1'b0, 8'h00);

    // Abort while waiting
    applyStimulus(1'b1, 12'h030, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 12'h030, 1'b0, 8'h00);
    applyStimulus(1'b0, 12'h030, 1'b1, 8'h00);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    checkOutput("abort_ctrl", 32'(ctrl_out), 32'h0);
    applyStimulus(1'b0, 12'h030, 1'b0, 8'h00);
    checkOutput("abort_no_done", 32'(done), 32'h0);

    // Asynchronous reset in the middle of a call chain
    applyStimulus(1'b1, 12'h100, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 12'h100, 1'b0, 8'h00);
    #2 areset = 1'b1;
    #1;
    checkOutput("areset_ctrl", 32'(ctrl_out), 32'h0);
    checkOutput("areset_upc", 32'(upc), 32'h0);
    checkOutput("areset_busy", 32'(busy), 32'h0);
    checkOutput("areset_done", 32'(done), 32'h0);
    checkOutput("areset_error", 32'(error), 32'h0);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;

    // Random programs in a small window, random conditions/aborts/starts
    for (int i = 0; i < 64; i++) begin
      rom[i] = mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  12'($urandom_range(0, 63)), 16'($urandom));
    end
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)),
                    ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
